// File: rtl/rsp_s1_prep_rd.sv
// rsp_s1_prep_rd: stage-1 differentiator feeder.
// Reads one frame of DATA_NUM packed RAM words and unpacks each word into
// BURST_LEN half-width samples. Each beat is presented with valid/last, and a
// per-frame mode flag is held for the whole frame. The read strobe and a last
// tag travel alongside the RAM latency so that the returned data can be
// captured.
module rsp_s1_prep_rd #(
    parameter int READ_RAM_WIDTH = 128,
    parameter int SAMPLE_WIDTH   = 32,
    parameter int DATA_NUM       = 1024,
    parameter int BURST_LEN      = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int RAM_LATENCY    = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           i_start,
    input  logic                                           i_switch,
    input  logic [ADDR_WIDTH-1:0]                          i_base_addr,
    input  logic                                           i_pause,
    output logic                                           o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0]                          o_ram_rd_addr,
    input  logic [READ_RAM_WIDTH-1:0]                      i_ram_rd_data,
    output logic [BURST_LEN-1:0][SAMPLE_WIDTH/2-1:0]       o_x0_data,
    output logic                                           o_x0_valid,
    output logic                                           o_x0_last,
    output logic                                           o_switch,
    output logic                                           o_busy,
    output logic                                           o_done
);

    localparam int HALF  = SAMPLE_WIDTH / 2;
    localparam int CNT_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   issue_last;
    logic [RAM_LATENCY-1:0] pipe_vld;
    logic [RAM_LATENCY-1:0] pipe_last;

    // Read issue: a read goes out on every unpaused READ cycle. o_ram_rd_addr
    // always shows the next address, so a pause holds it in place.
    always_comb begin
        o_ram_rd_en = (state == READ) && !i_pause;
        issue_last  = o_ram_rd_en && (beat_cnt == LAST_BEAT);
    end

    // Frame FSM: start capture, read issue and counting, drain wait, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            o_ram_rd_addr <= '0;
            o_switch      <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_switch      <= i_switch;
                        o_ram_rd_addr <= i_base_addr;
                        beat_cnt      <= '0;
                        o_busy        <= 1'b1;
                        state         <= READ;
                    end
                end
                READ: begin
                    if (o_ram_rd_en) begin
                        // The address register wraps modulo 2^ADDR_WIDTH.
                        o_ram_rd_addr <= o_ram_rd_addr + ADDR_WIDTH'(1);
                        beat_cnt      <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The pipeline is empty once the tagged last beat has been output.
                    if (o_x0_valid && o_x0_last) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Latency pipeline and output register: strobe/last tag are delayed by
    // RAM_LATENCY, then the returned word is unpacked and registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld   <= '0;
            pipe_last  <= '0;
            o_x0_valid <= 1'b0;
            o_x0_last  <= 1'b0;
            o_x0_data  <= '0;
        end else begin
            pipe_vld[0]  <= o_ram_rd_en;
            pipe_last[0] <= issue_last;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            o_x0_valid <= pipe_vld[RAM_LATENCY-1];
            o_x0_last  <= pipe_last[RAM_LATENCY-1];
            if (pipe_vld[RAM_LATENCY-1]) begin
                for (int unsigned k = 0; k < BURST_LEN; k++) begin
                    o_x0_data[k] <= i_ram_rd_data[k*HALF +: HALF];
                end
            end
        end
    end

endmodule

// File: tb/tb_rsp_s1_prep_rd.sv
// Testbench for rsp_s1_prep_rd: latency-2 RAM model, and a frame-level reference
// built from queues of expected read addresses and expected beats.
module tb_rsp_s1_prep_rd;

    localparam int DN  = 4;
    localparam int LAT = 2;
    localparam int AW  = 10;
    localparam int W   = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, i_start, i_switch, i_pause;
    logic [AW-1:0]        i_base_addr;
    logic                 o_ram_rd_en;
    logic [AW-1:0]        o_ram_rd_addr;
    logic [W-1:0]         i_ram_rd_data;
    logic [7:0][15:0]     o_x0_data;
    logic                 o_x0_valid, o_x0_last, o_switch, o_busy, o_done;

    rsp_s1_prep_rd #(
        .READ_RAM_WIDTH(W),
        .SAMPLE_WIDTH  (32),
        .DATA_NUM      (DN),
        .BURST_LEN     (8),
        .ADDR_WIDTH    (AW),
        .RAM_LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_switch     (i_switch),
        .i_base_addr  (i_base_addr),
        .i_pause      (i_pause),
        .o_ram_rd_en  (o_ram_rd_en),
        .o_ram_rd_addr(o_ram_rd_addr),
        .i_ram_rd_data(i_ram_rd_data),
        .o_x0_data    (o_x0_data),
        .o_x0_valid   (o_x0_valid),
        .o_x0_last    (o_x0_last),
        .o_switch     (o_switch),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // RAM with two cycles of read latency
    logic [W-1:0] mem [1024];
    logic [W-1:0] ram_d1;
    always @(posedge clk) begin
        ram_d1        <= mem[o_ram_rd_addr];
        i_ram_rd_data <= ram_d1;
    end

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic [AW-1:0] exp_addr[$];
    beat_t         exp_beats[$];
    int            strobe_q[$];
    beat_t         mb;
    int            cyc, last_cyc, s_cyc;
    logic [W-1:0]  last_data;
    logic          exp_sw;
    bit            mon_en;
    int            n_pass, n_checks;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Monitor: every observable event is compared against the expected frame.
    always @(negedge clk) begin
        if (!mon_en) begin
            exp_addr.delete();
            exp_beats.delete();
            strobe_q.delete();
            last_data = '0;
            last_cyc  = -100;
        end else begin
            cyc++;
            if (o_busy && exp_addr.size() > 0) begin
                check("rd_en", W'(o_ram_rd_en), W'(!i_pause));
                check("rd_addr", W'(o_ram_rd_addr), W'(exp_addr[0]));
                if (o_ram_rd_en) begin
                    void'(exp_addr.pop_front());
                    strobe_q.push_back(cyc);
                end
            end else if (o_ram_rd_en) begin
                check("spurious_rd", W'(o_ram_rd_en), W'(0));
            end
            if (o_x0_valid) begin
                if (exp_beats.size() == 0 || strobe_q.size() == 0) begin
                    check("spurious_valid", W'(o_x0_valid), W'(0));
                end else begin
                    mb    = exp_beats.pop_front();
                    s_cyc = strobe_q.pop_front();
                    check("data", o_x0_data, mb.data);
                    check("last", W'(o_x0_last), W'(mb.last));
                    check("latency", W'(cyc - s_cyc), W'(LAT + 1));
                    if (mb.last) last_cyc = cyc;
                end
                last_data = o_x0_data;
            end else begin
                check("data_hold", o_x0_data, last_data);
                check("last_idle", W'(o_x0_last), W'(0));
            end
            if (o_done) begin
                check("done_timing", W'(cyc - last_cyc), W'(1));
                check("busy_at_done", W'(o_busy), W'(0));
            end
            if (o_busy) check("switch", W'(o_switch), W'(exp_sw));
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"}, W'(o_ram_rd_en), W'(0));
        check({tag, "_addr"}, W'(o_ram_rd_addr), W'(0));
        check({tag, "_valid"}, W'(o_x0_valid), W'(0));
        check({tag, "_last"}, W'(o_x0_last), W'(0));
        check({tag, "_data"}, o_x0_data, W'(0));
        check({tag, "_switch"}, W'(o_switch), W'(0));
        check({tag, "_busy"}, W'(o_busy), W'(0));
        check({tag, "_done"}, W'(o_done), W'(0));
    endtask

    task automatic expect_frame(input logic [AW-1:0] base, input logic sw);
        logic [AW-1:0] a;
        for (int i = 0; i < DN; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_beats.push_back('{data: mem[a], last: (i == DN - 1)});
        end
        exp_sw = sw;
    endtask

    // pmode: 0 no pause, 1 three-cycle pause after two reads, 2 random pause
    task automatic run_frame(input logic [AW-1:0] base, input logic sw, input int pmode, input bit spam);
        int  pcnt;
        bit  done;
        expect_frame(base, sw);
        i_start     = 1'b1;
        i_switch    = sw;
        i_base_addr = base;
        @(posedge clk) #1;
        i_start = 1'b0;
        pcnt    = 0;
        done    = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            case (pmode)
                1: begin
                    i_pause = (DN - exp_addr.size() == 2) && (pcnt < 3);
                    if (i_pause) pcnt++;
                end
                2:       i_pause = ($urandom_range(0, 2) == 0);
                default: i_pause = 1'b0;
            endcase
            if (spam && o_busy) begin
                i_start     = 1'($urandom_range(0, 1));
                i_switch    = ~i_switch;
                i_base_addr = AW'($urandom);
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk) #1;
            i_start = 1'b0;
            if (o_done) done = 1;
        end
        i_pause = 1'b0;
        check("done_seen", W'(done), W'(1));
        check("reads_left", W'(exp_addr.size()), W'(0));
        check("beats_left", W'(exp_beats.size()), W'(0));
        check("switch_frame", W'(o_switch), W'(sw));
        @(posedge clk) #1;
    endtask

    initial begin
        rst = 1'b1; mon_en = 0; cyc = 0; n_pass = 0; n_checks = 0;
        i_start = 1'b0; i_switch = 1'b0; i_pause = 1'b0; i_base_addr = '0; exp_sw = 1'b0;
        for (int n = 0; n < 1024; n++)
            for (int k = 0; k < 8; k++)
                mem[n][k*16 +: 16] = 16'(8 * n + k);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mon_en = 1;
        @(negedge clk) check_idle("reset");
        @(posedge clk) #1;

        run_frame(AW'(0), 1'b0, 0, 0);       // basic frame
        run_frame(AW'(1022), 1'b0, 0, 0);    // address wrap
        run_frame(AW'(0), 1'b0, 1, 0);       // directed pause
        run_frame(AW'(100), 1'b1, 0, 1);     // mode flag, ignored restarts
        run_frame(AW'(200), 1'b0, 0, 0);     // new mode after done

        // reset after two reads: no beats, no done, clean restart
        expect_frame(AW'(300), 1'b1);
        i_start = 1'b1; i_switch = 1'b1; i_base_addr = AW'(300);
        @(posedge clk) #1;
        i_start = 1'b0;
        for (int c = 0; c < 20 && exp_addr.size() != DN - 2; c++) @(posedge clk) #1;
        check("two_reads", W'(exp_addr.size()), W'(DN - 2));
        i_pause = 1'b1; rst = 1'b1; mon_en = 0;
        @(posedge clk) #1;
        rst = 1'b0; i_pause = 1'b0; mon_en = 1;
        @(negedge clk) check_idle("midreset");
        repeat (8) @(posedge clk);
        #1;
        run_frame(AW'(0), 1'b1, 0, 0);

        for (int f = 0; f < 20; f++) begin
            for (int n = 0; n < 1024; n++) mem[n] = {$urandom, $urandom, $urandom, $urandom};
            run_frame(AW'($urandom), 1'($urandom), 2, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rsp_s1_prep_rd.md
Name: rsp_s1_prep_rd

Overview:
- Upstream feeder for the stage-1 differentiator: reads one frame of DATA_NUM packed beats from a block RAM with fixed read latency.
- Unpacks each READ_RAM_WIDTH word into BURST_LEN signed half-width samples.
- Presents each beat with valid and last, plus a per-frame mode flag for the differentiator.
- Started by a one-cycle command. Supports read pausing from the frame controller.

Parameters:
- READ_RAM_WIDTH, 128, RAM word width; must equal BURST_LEN*SAMPLE_WIDTH/2.
- SAMPLE_WIDTH, 32, complex sample width; each unpacked real sample is SAMPLE_WIDTH/2 bits.
- DATA_NUM, 1024, beats (RAM words) per frame.
- BURST_LEN, 8, samples per beat.
- ADDR_WIDTH, 10, RAM address width.
- RAM_LATENCY, 2, cycles from o_ram_rd_en to valid i_ram_rd_data; minimum 1.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous and active-high.
- i_start  in  1  one-cycle frame start; honoured only in IDLE.
- i_switch  in  1  mode flag; sampled when i_start is accepted.
- i_base_addr  in  ADDR_WIDTH  first RAM address of the frame; sampled when i_start is accepted.
- i_pause  in  1  when high, no new RAM reads are issued.
- o_ram_rd_en  out  1  RAM read strobe.
- o_ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- i_ram_rd_data  in  READ_RAM_WIDTH  RAM read data.
- o_x0_data  out  [BURST_LEN-1:0] x SAMPLE_WIDTH/2 signed  unpacked samples.
- o_x0_valid  out  1  beat valid.
- o_x0_last  out  1  final beat of the frame.
- o_switch  out  1  registered mode flag, held for the whole frame.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset values: all outputs 0; o_x0_data all 0; FSM in IDLE; counters cleared; read-latency pipeline flushed.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - i_start=1 latches i_switch into o_switch and i_base_addr into the address register.
  - Clears the beat counter, sets o_busy, moves to READ.
- READ:
  - Each cycle with i_pause=0 asserts o_ram_rd_en with o_ram_rd_addr = base + beat count, taken mod 2^ADDR_WIDTH (address wraps silently).
  - Beat count increments on each issued read. With i_pause=1, o_ram_rd_en=0 and the address is held.
  - After read number DATA_NUM-1 is issued, moves to DRAIN.
- DRAIN:
  - No reads are issued.
  - Stays until the in-flight pipeline is empty, i.e. the last beat has been output; then moves to DONE.
- DONE: o_done=1 for one cycle, o_busy drops in the same cycle, returns to IDLE.
- i_start outside IDLE is ignored; o_switch and the base address are not re-sampled.
- Read-latency pipeline:
  - The read strobe and a last tag (set on beat DATA_NUM-1) travel through a RAM_LATENCY-deep shift register.
  - At the tail, i_ram_rd_data is unpacked and registered.
  - o_x0_valid therefore follows o_ram_rd_en by exactly RAM_LATENCY+1 cycles; o_x0_last is aligned with the final valid beat.
- Unpacking: o_x0_data[k] = i_ram_rd_data[k*SAMPLE_WIDTH/2 +: SAMPLE_WIDTH/2]. No arithmetic, no sign change.
- o_x0_data holds its last value when o_x0_valid=0.
- i_pause only stalls issue. Reads already in flight are always delivered; no backpressure on the output.
- Pause toggling during READ produces gaps in o_x0_valid. Beat order and count are unchanged.
- rst mid-frame:
  - Next cycle is IDLE with all outputs 0.
  - In-flight beats are discarded and no o_done is produced.
  - RAM data returning after reset is ignored.
- DATA_NUM=1: READ issues a single read flagged last, then goes to DRAIN.

Test Plan:
- Basic frame, DATA_NUM=4, RAM_LATENCY=2, base 0, RAM word n = per-sample values 8n..8n+7:
  - Reads at addr 0..3 on 4 consecutive cycles.
  - o_x0_valid high 3 cycles after each strobe; o_x0_data[k] = 8n+k.
  - o_x0_last only on beat 3; o_done one cycle after the last valid.
- Address wrap, ADDR_WIDTH=10, base 1022, DATA_NUM=4 -> addresses 1022, 1023, 0, 1.
- Pause: i_pause high for 3 cycles after beat 1:
  - o_ram_rd_en low 3 cycles with address held at 2.
  - Output shows a 3-cycle valid gap; total 4 beats, last on beat 3.
- Mode flag: start with i_switch=1, then toggle i_switch and pulse i_start mid-frame:
  - o_switch stays 1 and the second start is ignored.
  - A new start after o_done with i_switch=0 gives o_switch=0.
- Reset mid-frame: assert rst after 2 reads:
  - All outputs 0 the next cycle; no valid beats from the 2 in-flight reads.
  - No o_done; a fresh start afterwards runs a clean frame.
